// File: rtl/stdcore_rf_fifo_ctrl_if.sv
// Producer/consumer ready-valid streams plus occupancy for stdcore_rf_fifo_ctrl.
interface stdcore_rf_fifo_ctrl_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;

  // Environment side: produces into and consumes from the FIFO.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/stdcore_rf_fifo_ctrl.sv
// FIFO controller over a 2-port RF macro (1-cycle read latency) with a 2-entry output buffer.
// Optional empty-FIFO path straight into the output buffer: define STDCORE_FIFO_BYPASS_EN.
module stdcore_rf_fifo_ctrl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  stdcore_rf_fifo_ctrl_if.slave io,
  output logic                  mem_we_n,
  output logic [AW-1:0]         mem_waddr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_re_n,
  output logic [AW-1:0]         mem_raddr,
  input  logic [DW-1:0]         mem_rdata
);
  localparam int unsigned   CW   = AW + 1;
  localparam int unsigned   LW   = AW + 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] ob0_q, ob0_d;
  logic [DW-1:0] ob1_q, ob1_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;

  logic          in_ready_c, push_c, pop_c, issue_c, byp_c, wr_c, land_c;
  logic [2:0]    occ_c;
  logic [1:0]    ob_after_c;
  logic [DW-1:0] land_data_c;

  always_comb begin
    in_ready_c  = (ram_cnt_q < FULL);
    push_c      = io.in_valid & in_ready_c & ~rst;
    pop_c       = (ob_cnt_q != 2'd0) & io.out_ready;
    // Read only if the returning word is guaranteed a buffer slot after this pop.
    occ_c       = 3'(ob_cnt_q) + 3'(rd_pend_q);
    issue_c     = (ram_cnt_q != '0) && (occ_c <= (3'd1 + 3'(pop_c)));
    ob_after_c  = ob_cnt_q - 2'(pop_c);
`ifdef STDCORE_FIFO_BYPASS_EN
    byp_c       = push_c && (ram_cnt_q == '0) && !rd_pend_q && (ob_after_c <= 2'd1);
`else
    byp_c       = 1'b0;
`endif
    wr_c        = push_c & ~byp_c;
    land_c      = rd_pend_q | byp_c;
    land_data_c = rd_pend_q ? mem_rdata : io.in_data;

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (wr_c)    wptr_d = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
    if (issue_c) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + AW'(1);
    ram_cnt_d = ram_cnt_q + CW'(wr_c) - CW'(issue_c);
    rd_pend_d = issue_c;

    // Shift on pop first, then drop the arriving word into the first free slot.
    ob0_d = ob0_q;
    ob1_d = ob1_q;
    if (pop_c) ob0_d = ob1_q;
    if (land_c) begin
      if (ob_after_c == 2'd0) ob0_d = land_data_c;
      else                    ob1_d = land_data_c;
    end
    ob_cnt_d = ob_after_c + 2'(land_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      ob0_q     <= '0;
      ob1_q     <= '0;
      ob_cnt_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      ob0_q     <= ob0_d;
      ob1_q     <= ob1_d;
      ob_cnt_q  <= ob_cnt_d;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = (ob_cnt_q != 2'd0);
  assign io.out_data  = ob0_q;
  assign io.level     = LW'(ram_cnt_q) + LW'(rd_pend_q) + LW'(ob_cnt_q);

  assign mem_we_n  = ~wr_c;
  assign mem_waddr = wptr_q;
  assign mem_wdata = io.in_data;
  assign mem_re_n  = ~issue_c;
  assign mem_raddr = rptr_q;
endmodule

// File: tb/tb_stdcore_rf_fifo_ctrl.sv
// Directed and random checks of stdcore_rf_fifo_ctrl against a behavioural RF and a queue model.
module tb_stdcore_rf_fifo_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = AW + 2;
  localparam int unsigned NWRAP = 4 * DEPTH;
`ifdef STDCORE_FIFO_BYPASS_EN
  localparam int  EMPTY_LAT = 1;
  localparam logic BYP      = 1'b1;
`else
  localparam int  EMPTY_LAT = 3;
  localparam logic BYP      = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          mem_we_n, mem_re_n;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks;
  int n_fail;

  stdcore_rf_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  stdcore_rf_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus),
    .mem_we_n  (mem_we_n),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re_n  (mem_re_n),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  // Register-file macro: synchronous write, registered read data.
  logic [DW-1:0] rf [0:(1<<AW)-1];
  logic [DW-1:0] rf_rdata;
  always @(posedge clk) begin
    if (!mem_we_n) rf[mem_waddr] <= mem_wdata;
    if (!mem_re_n) rf_rdata <= rf[mem_raddr];
  end
  assign mem_rdata = rf_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive at edge+1, sample at edge+2, return at next edge+1.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                      output logic pushed, output logic popped,
                      output logic [DW-1:0] pdata, output logic clash);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    pushed = iv & bus.in_ready;
    popped = bus.out_valid & ordy;
    pdata  = bus.out_data;
    clash  = !mem_we_n && !mem_re_n && (mem_raddr == mem_waddr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (mem_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n c%0d: got %b want 1", i, mem_we_n); end
    end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_checks++; if (mem_re_n !== 1'b1) begin n_fail++; $display("FAIL reset_re_n: got %b want 1", mem_re_n); end
    n_checks++; if (mem_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", mem_waddr); end
    n_checks++; if (mem_raddr !== '0) begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", mem_raddr); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.level !== '0) begin n_fail++; $display("FAIL post_reset_level: got %0d want 0", bus.level); end
  endtask

  task automatic test_single_push();
    logic we_n0, pu, po, cl;
    logic [DW-1:0] d;
    int first;
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_A5A5; bus.out_ready = 1'b0;
    #1; we_n0 = mem_we_n;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = '0;
    first = -1;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (first < 0 && bus.out_valid === 1'b1) first = c;
      @(posedge clk); #1;
    end
    n_checks++; if (we_n0 !== BYP) begin n_fail++; $display("FAIL single_we_n: got %b want %b", we_n0, BYP); end
    n_checks++; if (first != EMPTY_LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first, EMPTY_LAT); end
    n_checks++; if (bus.out_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL single_data: got %h want a5a5a5a5", bus.out_data); end
    n_checks++; if (bus.level !== LW'(1)) begin n_fail++; $display("FAIL single_level: got %0d want 1", bus.level); end
    step(1'b0, '0, 1'b1, pu, po, d, cl);
    n_checks++; if (po !== 1'b1 || d !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL single_pop: got %b/%h want 1/a5a5a5a5", po, d); end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin n_fail++; $display("FAIL single_empty: got %b/%0d want 0/0", bus.out_valid, bus.level); end
  endtask

  task automatic test_full_drain();
    logic pu, po, cl;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, DW'(i), 1'b0, pu, po, d, cl);
      n_checks++; if (pu !== 1'b1) begin n_fail++; $display("FAIL full_push %0d: in_ready got %b want 1", i, pu); end
    end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.level !== LW'(DEPTH + 2)) begin n_fail++; $display("FAIL full_level: got %0d want %0d", bus.level, DEPTH + 2); end
    step(1'b1, 32'hFFFF_FFFF, 1'b0, pu, po, d, cl);
    n_checks++; if (pu !== 1'b0) begin n_fail++; $display("FAIL full_reject: pushed got %b want 0", pu); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == 2) begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen: in_ready got %b want 1", bus.in_ready); end
      end
      step(1'b0, '0, 1'b1, pu, po, d, cl);
      n_checks++;
      if (po !== 1'b1 || d !== DW'(i)) begin n_fail++; $display("FAIL drain_%0d: got %b/%0d want 1/%0d", i, po, d, i); end
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin n_fail++; $display("FAIL drain_empty: got %b/%0d want 0/0", bus.out_valid, bus.level); end
  endtask

  task automatic test_wrap();
    logic pu, po, cl;
    logic [DW-1:0] d;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < NWRAP && cyc < 200) begin
      step(sent < NWRAP, DW'(32'h100 + sent), 1'b1, pu, po, d, cl);
      n_checks++; if (cl !== 1'b0) begin n_fail++; $display("FAIL wrap_addr_clash c%0d: got %b want 0", cyc, cl); end
      if (pu) sent++;
      if (po) begin
        n_checks++;
        if (d !== DW'(32'h100 + got)) begin n_fail++; $display("FAIL wrap_data %0d: got %h want %h", got, d, 32'h100 + got); end
        got++;
      end
      cyc++;
    end
    n_checks++; if (got != NWRAP) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", got, NWRAP); end
    n_checks++; if (cyc != NWRAP + EMPTY_LAT) begin n_fail++; $display("FAIL wrap_rate: cycles got %0d want %0d", cyc, NWRAP + EMPTY_LAT); end
  endtask

  task automatic test_random();
    logic pu, po, cl, iv, ordy;
    logic [DW-1:0] d, din;
    logic [DW-1:0] model[$];
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      din  = $urandom;
      step(iv, din, ordy, pu, po, d, cl);
      if (po) begin
        n_checks++;
        if (model.size() == 0) begin n_fail++; $display("FAIL rand_underflow c%0d: got %h want none", c, d); end
        else begin
          if (d !== model[0]) begin n_fail++; $display("FAIL rand_data c%0d: got %h want %h", c, d, model[0]); end
          void'(model.pop_front());
        end
      end
      if (pu) model.push_back(din);
      n_checks++;
      if (bus.level !== LW'(model.size())) begin n_fail++; $display("FAIL rand_level c%0d: got %0d want %0d", c, bus.level, model.size()); end
    end
    for (int c = 0; c < 40 && model.size() > 0; c++) begin
      step(1'b0, '0, 1'b1, pu, po, d, cl);
      if (po) begin
        n_checks++;
        if (d !== model[0]) begin n_fail++; $display("FAIL rand_drain: got %h want %h", d, model[0]); end
        void'(model.pop_front());
      end
    end
    n_checks++; if (model.size() != 0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_final: left %0d valid %b want 0/0", model.size(), bus.out_valid); end
  endtask

  task automatic test_reset_midop();
    logic pu, po, cl;
    logic [DW-1:0] d;
    int pops;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h200 + i), 1'b0, pu, po, d, cl);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, pu, po, d, cl);
    step(1'b0, '0, 1'b1, pu, po, d, cl);
    n_checks++; if (po !== 1'b1 || d !== 32'h200) begin n_fail++; $display("FAIL midop_pop: got %b/%h want 1/200", po, d); end
    n_checks++; if (bus.level !== LW'(3)) begin n_fail++; $display("FAIL midop_level: got %0d want 3", bus.level); end
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_rst_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.level !== '0) begin n_fail++; $display("FAIL midop_rst_level: got %0d want 0", bus.level); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 32'h0000_600D, 1'b0, pu, po, d, cl);
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, '0, 1'b1, pu, po, d, cl);
      if (po) begin
        pops++;
        n_checks++;
        if (d !== 32'h0000_600D) begin n_fail++; $display("FAIL midop_data: got %h want 0000600d", d); end
      end
    end
    n_checks++; if (pops != 1) begin n_fail++; $display("FAIL midop_pops: got %0d want 1", pops); end
    n_checks++; if (bus.level !== '0) begin n_fail++; $display("FAIL midop_final_level: got %0d want 0", bus.level); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_full_drain();
    test_wrap();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
